// File: rtl/axil_sram_responder.sv
// AXI4-Lite-style SRAM responder with independent read/write channels and
// a configurable (fixed or LFSR-driven pseudo-random) per-transaction latency.
module axil_sram_responder #(
    parameter logic [31:0] ADDR_BASE    = 32'h8000_0000,
    parameter int          DEPTH_WORDS  = 4096,
    parameter bit          RANDOM_DELAY = 1'b1,
    parameter logic [7:0]  DELAY_MASK   = 8'h1f,
    parameter logic [7:0]  FIXED_DELAY  = 8'd0,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5,
    parameter              INIT_FILE    = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_arvalid,
    output logic        mem_arready,
    input  logic [31:0] mem_araddr,
    output logic        mem_rvalid,
    input  logic        mem_rready,
    output logic [31:0] mem_rdata,
    output logic [1:0]  mem_rresp,
    input  logic        mem_awvalid,
    output logic        mem_awready,
    input  logic [31:0] mem_awaddr,
    input  logic        mem_wvalid,
    output logic        mem_wready,
    input  logic [31:0] mem_wdata,
    input  logic [7:0]  mem_wstrb,
    output logic        mem_bvalid,
    input  logic        mem_bready,
    output logic [1:0]  mem_bresp
);

    localparam int          IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    function automatic logic in_range(input logic [31:0] addr);
        return (addr >= ADDR_BASE) && (((addr - ADDR_BASE) >> 2) < 32'(DEPTH_WORDS));
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [31:0] addr);
        return IDX_W'((addr - ADDR_BASE) >> 2);
    endfunction

    // NOTE: memories get no reset; contents survive rst and are only defined once written or preloaded.
    logic [31:0] mem [DEPTH_WORDS];

    // ---------------- latency source ----------------
    logic [7:0] lfsr;
    logic [7:0] delay;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) lfsr <= LFSR_SEED;
        else     lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
    end

    assign delay = RANDOM_DELAY ? (lfsr & DELAY_MASK) : FIXED_DELAY;

    // ---------------- read channel ----------------
    r_state_t         r_state, r_next;
    logic [31:0]      r_addr;
    logic [7:0]       r_cnt;
    logic [IDX_W-1:0] r_idx;

    assign mem_arready = (r_state == R_IDLE) && !rst;
    assign r_idx       = word_index(r_addr);

    // NOTE: next-state is assigned a default first so no path through the case infers a latch.
    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:  if (mem_arvalid && mem_arready) r_next = R_WAIT;
            R_WAIT:  if (r_cnt == 8'd0)              r_next = R_RESP;
            R_RESP:  if (mem_rready)                 r_next = R_IDLE;
            default:                                 r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= R_IDLE;
            r_addr     <= '0;
            r_cnt      <= '0;
            mem_rvalid <= 1'b0;
            mem_rdata  <= '0;
            mem_rresp  <= RESP_OKAY;
        end else begin
            r_state <= r_next;
            unique case (r_state)
                R_IDLE: begin
                    if (mem_arvalid && mem_arready) begin
                        r_addr <= mem_araddr;
                        r_cnt  <= delay;
                    end
                end
                R_WAIT: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else begin
                        mem_rvalid <= 1'b1;
                        mem_rdata  <= in_range(r_addr) ? mem[r_idx] : 32'h0;
                        mem_rresp  <= in_range(r_addr) ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                R_RESP: begin
                    if (mem_rready) begin
                        mem_rvalid <= 1'b0;
                        mem_rdata  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- write channel ----------------
    w_state_t         w_state, w_next;
    logic             aw_got, w_got;
    logic             aw_hs, w_hs, w_commit;
    logic [31:0]      w_addr, w_data;
    logic [3:0]       w_strb;
    logic [7:0]       w_cnt;
    logic [IDX_W-1:0] w_idx;
    logic             unused_wstrb_hi;

    // Only four byte lanes exist on a 32-bit word.
    assign unused_wstrb_hi = ^mem_wstrb[7:4];

    assign mem_awready = (w_state == W_IDLE) && !aw_got && !rst;
    assign mem_wready  = (w_state == W_IDLE) && !w_got && !rst;
    assign aw_hs       = mem_awvalid && mem_awready;
    assign w_hs        = mem_wvalid && mem_wready;
    assign w_commit    = (w_state == W_WAIT) && (w_cnt == 8'd0);
    assign w_idx       = word_index(w_addr);

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE:  if ((aw_got || aw_hs) && (w_got || w_hs)) w_next = W_WAIT;
            W_WAIT:  if (w_cnt == 8'd0)                         w_next = W_RESP;
            W_RESP:  if (mem_bready)                            w_next = W_IDLE;
            default:                                            w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state    <= W_IDLE;
            aw_got     <= 1'b0;
            w_got      <= 1'b0;
            w_addr     <= '0;
            w_data     <= '0;
            w_strb     <= '0;
            w_cnt      <= '0;
            mem_bvalid <= 1'b0;
            mem_bresp  <= RESP_OKAY;
        end else begin
            w_state <= w_next;
            unique case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_got <= 1'b1;
                        w_addr <= mem_awaddr;
                    end
                    if (w_hs) begin
                        w_got  <= 1'b1;
                        w_data <= mem_wdata;
                        w_strb <= mem_wstrb[3:0];
                    end
                    if (w_next == W_WAIT) w_cnt <= delay;
                end
                W_WAIT: begin
                    if (w_cnt != 8'd0) begin
                        w_cnt <= w_cnt - 8'd1;
                    end else begin
                        mem_bvalid <= 1'b1;
                        mem_bresp  <= in_range(w_addr) ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                W_RESP: begin
                    if (mem_bready) begin
                        mem_bvalid <= 1'b0;
                        aw_got     <= 1'b0;
                        w_got      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // A reset on the commit edge drops the write along with the transaction.
    always_ff @(posedge clk) begin
        if (w_commit && !rst && in_range(w_addr)) begin
            for (int i = 0; i < 4; i++) begin
                if (w_strb[i]) mem[w_idx][8*i +: 8] <= w_data[8*i +: 8];
            end
        end
    end

endmodule
